// File: rtl/walk_seq_detect.sv
// -----------------------------------------------------------------------------
// walk_seq_detect
//   Runtime detector for the descending walking-bit chain over an N-bit vector:
//   bit N-1 high, then bit N-2 high on the next valid sample, and so on down
//   to bit 0. A one-cycle match pulse is produced each time a chain completes,
//   and a saturating completion counter plus a sticky "seen" flag are kept.
//   Overlapping chains are tracked in parallel by the partial-match vector.
//
// Parameters
//   N      vector width (1..8)
//   CW     counter width (1..16)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   vld    in   sample qualifier; vect is examined only when high
//   vect   in   N-bit vector from the upstream pass-through stage
//   clr    in   synchronous clear of count and seen (chain tracking unaffected)
//   match  out  one-cycle pulse: chain completed on the previous valid sample
//   count  out  completed chains, saturating at 2^CW-1
//   seen   out  sticky; set by the first match after reset or clr
// -----------------------------------------------------------------------------
module walk_seq_detect #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic [N-1:0]  vect,
  input  logic          clr,
  output logic          match,
  output logic [CW-1:0] count,
  output logic          seen
);

  // Elaboration-time parameter checks.
  generate
    if (N < 1 || N > 8) begin : g_bad_n
      $error("Parameter N has an invalid value of %0d", N);
    end
    if (CW < 1 || CW > 16) begin : g_bad_cw
      $error("Parameter CW has an invalid value of %0d", CW);
    end
    if (N == 1) begin : g_single
      $info("single-bit chain");
    end
  endgenerate

  localparam logic [CW-1:0] CountMax = {CW{1'b1}};

  // p_q[k] = 1: vect[N-1]..vect[k] were high on successive valid samples,
  // ending at the most recent one. Several bits may be set at once.
  logic [N-1:0]  p_q, p_d;
  logic          match_q, match_d;
  logic [CW-1:0] count_q, count_d;
  logic          seen_q, seen_d;
  logic          done;

  // Chain completes when the final bit lands on top of a full prefix.
  generate
    if (N == 1) begin : g_done_one
      assign done = vect[0];
    end else begin : g_done_n
      assign done = p_q[1] & vect[0];
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    p_d     = p_q;
    match_d = 1'b0;
    count_d = count_q;
    seen_d  = seen_q;

    // Invalid cycles stall the chain: p holds, match drops.
    if (vld) begin
      p_d[N-1] = vect[N-1];
      for (int k = 0; k < N - 1; k++) begin
        p_d[k] = p_q[k+1] & vect[k];
      end
      match_d = done;
    end

    if (match_d) begin
      seen_d = 1'b1;
      if (count_q != CountMax) begin
        count_d = count_q + CW'(1);
      end
    end

    // clr wins over an increment in the same cycle but leaves p/match alone.
    if (clr) begin
      count_d = '0;
      seen_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      p_q     <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      match_q <= match_d;
      count_q <= count_d;
      seen_q  <= seen_d;
    end
  end

  assign match = match_q;
  assign count = count_q;
  assign seen  = seen_q;

endmodule

// File: tb/tb_walk_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_walk_seq_detect
//   Self-checking bench for walk_seq_detect. Three instances share stimulus:
//   N=4/CW=8 (main), N=4/CW=2 (saturation), N=1/CW=8 (single-bit chain).
//   Expected values come from a directed table, explicit hand checks and a
//   reference model that keeps a history of valid samples and tests the
//   chain rule directly on it.
// -----------------------------------------------------------------------------
module tb_walk_seq_detect;

  logic       clk = 1'b0;
  logic       rst, vld, clr;
  logic [3:0] vect;

  logic       match4, match_s, match1;
  logic [7:0] count4, count1;
  logic [1:0] count_s;
  logic       seen4, seen_s, seen1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  walk_seq_detect #(.N(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .vld(vld), .vect(vect), .clr(clr),
    .match(match4), .count(count4), .seen(seen4)
  );

  walk_seq_detect #(.N(4), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .vld(vld), .vect(vect), .clr(clr),
    .match(match_s), .count(count_s), .seen(seen_s)
  );

  walk_seq_detect #(.N(1), .CW(8)) dut_one (
    .clk(clk), .rst(rst), .vld(vld), .vect(vect[0:0]), .clr(clr),
    .match(match1), .count(count1), .seen(seen1)
  );

  // ---------------- reference model ----------------
  logic [3:0] hist[$];            // valid samples, oldest first
  int m_n  [3] = '{4, 4, 1};
  int m_max[3] = '{255, 3, 255};
  int m_match[3], m_count[3], m_seen[3];

  // True when the last n valid samples carry bits n-1 .. 0 in order.
  function automatic bit chain_done(int n);
    if (hist.size() < n) return 1'b0;
    for (int j = 0; j < n; j++)
      if (!hist[hist.size() - n + j][n - 1 - j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update(input logic v, input logic [3:0] d,
                              input logic c, input logic r);
    if (r) begin
      hist.delete();
      for (int i = 0; i < 3; i++) begin
        m_match[i] = 0; m_count[i] = 0; m_seen[i] = 0;
      end
    end else begin
      if (v) begin
        hist.push_back(d);
        if (hist.size() > 8) void'(hist.pop_front());
      end
      for (int i = 0; i < 3; i++) begin
        m_match[i] = (v && chain_done(m_n[i])) ? 1 : 0;
        if (c) begin
          m_count[i] = 0;
          m_seen[i]  = 0;
        end else if (m_match[i] == 1) begin
          if (m_count[i] < m_max[i]) m_count[i]++;
          m_seen[i] = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_match4",  int'(match4),  m_match[0]);
    check("model_count4",  int'(count4),  m_count[0]);
    check("model_seen4",   int'(seen4),   m_seen[0]);
    check("model_match_s", int'(match_s), m_match[1]);
    check("model_count_s", int'(count_s), m_count[1]);
    check("model_seen_s",  int'(seen_s),  m_seen[1]);
    check("model_match1",  int'(match1),  m_match[2]);
    check("model_count1",  int'(count1),  m_count[2]);
    check("model_seen1",   int'(seen1),   m_seen[2]);
  endtask

  // Apply one cycle of stimulus, advance the model at the same edge, then
  // optionally compare all outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c,
                      input logic r, input bit cmp);
    vld = v; vect = d; clr = c; rst = r;
    @(posedge clk);
    model_update(v, d, c, r);
    #1;
    if (cmp) compare_model();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    logic       r;
    logic       em;
    logic [7:0] ec;
    logic       es;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1; vld = 1'b0; clr = 1'b0; vect = 4'b0000;

    // Expected outputs are those of the N=4/CW=8 instance after the row's edge.
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0}); // reset
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1}); // complete
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1}); // broken
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}); // clr

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r, 1'b0);
      check($sformatf("tbl%0d_match", i), int'(match4), int'(tbl[i].em));
      check($sformatf("tbl%0d_count", i), int'(count4), int'(tbl[i].ec));
      check($sformatf("tbl%0d_seen",  i), int'(seen4),  int'(tbl[i].es));
    end

    // ---------------- stall: 3 invalid cycles between samples ----------------
    begin
      logic [3:0] seq[4];
      int pulses;
      seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      pulses = 0;
      step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        step(1'b1, seq[i], 1'b0, 1'b0, 1'b1);
        if (match4) pulses++;
        if (i == 3) check("stall_match_after_last", int'(match4), 1);
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
          if (match4) pulses++;
        end
      end
      check("stall_pulses", pulses, 1);
      check("stall_count", int'(count4), 1);
    end

    // ---------------- overlap: 1111 on 6 valid cycles ----------------
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      check($sformatf("overlap_match%0d", i), int'(match4), (i >= 3) ? 1 : 0);
    end
    check("overlap_count", int'(count4), 3);

    // ---------------- saturation (CW=2) and clr on a completing sample -------
    step(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
      if (i >= 5) check($sformatf("sat_count%0d", i), int'(count_s), 3);
    end
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("clr_match_s", int'(match_s), 1);
    check("clr_count_s", int'(count_s), 0);
    check("clr_seen_s",  int'(seen_s),  0);
    check("clr_count4",  int'(count4),  0);

    // ---------------- reset mid-chain ----------------
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("rst_match4", int'(match4), 0);
    check("rst_count4", int'(count4), 0);
    check("rst_seen4",  int'(seen4),  0);
    step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    check("rst_no_match4", int'(match4), 0);
    check("n1_match",      int'(match1), 1);
    check("n1_count",      int'(count1), 1);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 3000; i++) begin
      logic       v, c, r;
      logic [3:0] d;
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom | $urandom);
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, d, c, r, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/walk_seq_detect.md
# walk_seq_detect

Runtime detector for the descending walking-bit chain over an N-bit vector. The chain is bit N-1, then bit N-2 on the next valid sample, down to bit 0. The block sits downstream of the N-bit pass-through stage and consumes its `out` vector as `vect`. It raises a one-cycle `match` pulse each time the chain completes and keeps a saturating count of completions. Overlapping chains are detected independently.

## Interface
- `N`, 4: vector width; legal range 1..8.
- `CW`, 8: width of the match counter; legal range 1..16.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `vld`  in  1  sample qualifier; `vect` is examined only when high.
- `vect`  in  N  vector from the upstream pass-through stage.
- `clr`  in  1  synchronous clear of `count` and `seen`; does not affect chain tracking.
- `match`  out  1  one-cycle pulse; the chain completed on the previous valid sample.
- `count`  out  CW  number of completed chains, saturating at 2^CW-1.
- `seen`  out  1  sticky; set by the first `match` after reset or `clr`.

## Operation
- Elaboration checks use conditional generate `$error`:
  - N<1 or N>8: "Parameter N has an invalid value of %0d".
  - CW<1 or CW>16: same form, naming CW.
  - N==1: `$info` "single-bit chain".
- Internal partial-match register `p[N-1:0]`. `p[k]`=1 means `vect[N-1]..vect[k]` were seen high on successive valid samples, ending at the most recent one.
- On a cycle with `vld`=1:
  - `p[N-1]` <= `vect[N-1]`.
  - `p[k]` <= `p[k+1] & vect[k]`, for k = N-2..0.
  - `match` <= `p[1] & vect[0]`, or `vect[0]` when N==1.
- On a cycle with `vld`=0:
  - `p` holds.
  - `match` <= 0.
  - Invalid cycles stall the chain; they never break it.
- Several `p` bits may be set at once, so overlapping chains progress in parallel. No dedicated FSM: `p` is the state, 2^N encodings.
- `count`:
  - Increments by 1 in the same cycle `match` is set.
  - Holds at 2^CW-1; no wrap.
- `seen` is set in the same cycle as the first `match`.
- `clr`:
  - `count` <= 0 and `seen` <= 0, overriding any increment in that cycle.
  - The `match` pulse and `p` update normally in that cycle.
- `rst` overrides everything: `p`=0, `match`=0, `count`=0, `seen`=0.

## Timing
- All outputs are registered.
- Reset values: `match`=0, `count`=0, `seen`=0.
- Latency:
  - `match` is high the cycle after the valid sample carrying `vect[0]`=1 that completes the chain.
  - `count` and `seen` reflect that match in the same cycle as `match`.
- Minimum chain duration is N valid samples. Maximum duration is unbounded, because stalls are allowed.
- Simultaneous `clr` and a completing sample: `match`=1, `count`=0, `seen`=0 in the next cycle.
- Reset mid-chain discards all partial matches. The first `match` after reset requires N fresh valid samples.
- Back-to-back `match` pulses on consecutive valid cycles are legal, for example when `vect` is held all-ones.

## Test plan
- N=4, `vld`=1:
  - Stimulus: `vect` = 1000, 0100, 0010, 0001 on cycles 0-3.
  - Response: `match`=1 only on cycle 4; `count`=1 and `seen`=1 from cycle 4.
- Stall:
  - Stimulus: same sequence with `vld`=0 for 3 cycles between each sample; `vect` = 0000 during the stalls.
  - Response: exactly one `match`, one cycle after the 0001 sample; `count`=1.
- Broken chain:
  - Stimulus: 1000, 0100, 0000, 0001, then 0001.
  - Response: `match` stays 0 throughout; `count`=0.
- Overlap:
  - Stimulus: `vect`=1111 on 6 consecutive valid cycles.
  - Response: `match` high on cycles 4, 5 and 6; `count`=3.
- Saturation and clear, CW=2:
  - Stimulus: 5 matches, then `clr` on the cycle of a 6th completing sample.
  - Response: `count`=3 after matches 3-5. Next cycle after the `clr`: `match`=1, `count`=0, `seen`=0.
- Reset mid-chain:
  - Stimulus: assert `rst` for 1 cycle after 1000, 0100, 0010, then apply 0001.
  - Response: no `match`, and all outputs are 0 after reset. Also: N=1 with `vect`=1 on a valid cycle gives `match` the next cycle.
